// File: rtl/sdi_tx_vid_framer_if.sv
// Port bundle for sdi_tx_vid_framer: parallel 4:2:2 video in, 20-bit SDI words out.
// master drives video and the word strobe; slave is the framer.
interface sdi_tx_vid_framer_if;
    logic        enable;
    logic [23:0] vid_data;
    logic        vid_de;
    logic        vid_hsync;
    logic        vid_vsync;
    logic [19:0] dout;
    logic        dout_valid;
    logic        trs;
    logic [10:0] ln;
    logic        fmt_err;

    modport master (
        output enable, vid_data, vid_de, vid_hsync, vid_vsync,
        input  dout, dout_valid, trs, ln, fmt_err
    );

    modport slave (
        input  enable, vid_data, vid_de, vid_hsync, vid_vsync,
        output dout, dout_valid, trs, ln, fmt_err
    );
endinterface

// File: rtl/sdi_tx_vid_framer.sv
// HD-SDI transmit framer: inserts EAV/SAV with XYZ, blanking codes and line number.
// Optional macro SDI_FMT_CLIP_EN clips active picture data out of the TRS code range.
module sdi_tx_vid_framer #(
    parameter int unsigned LINES_PER_FRAME = 1125,
    parameter int unsigned VSYNC_LN        = 1122
) (
    input logic                clk,
    input logic                rst,
    sdi_tx_vid_framer_if.slave bus
);
    localparam int unsigned CW    = 10;
    localparam int unsigned LN_W  = 11;
    localparam int unsigned WIN_W = 3;
    localparam int unsigned SAV_W = 2;

    localparam logic [CW-1:0] BLANK_Y  = 10'h040;
    localparam logic [CW-1:0] BLANK_C  = 10'h200;
    localparam logic [CW-1:0] TRS_ONES = 10'h3FF;

    typedef struct packed {
        logic [CW-1:0] y;
        logic [CW-1:0] c;
        logic          hs;
        logic          vs;
        logic          de;
    } stage_t;

    localparam stage_t FILL = {BLANK_Y, BLANK_C, 1'b1, 1'b1, 1'b0};

    // TRS word at position idx (3FF, 000, 000, XYZ); field bit F is fixed 0 (progressive)
    function automatic logic [CW-1:0] trs_word(input logic [1:0] idx, input logic v, input logic h);
        logic f;
        f = 1'b0;
        case (idx)
            2'd0:    trs_word = TRS_ONES;
            2'd3:    trs_word = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
            default: trs_word = '0;
        endcase
    endfunction

    function automatic logic [CW-1:0] act_word(input logic [CW-1:0] x);
`ifdef SDI_FMT_CLIP_EN
        if (x < 10'h004) begin
            act_word = 10'h004;
        end else if (x > 10'h3FB) begin
            act_word = 10'h3FB;
        end else begin
            act_word = x;
        end
`else
        act_word = x;
`endif
    endfunction

    stage_t din;
    stage_t d0, d1, d2, d3;

    logic             hs_last;
    logic             vs_last;
    logic             vs_rose;
    logic             v_line;
    logic             win_act;
    logic [WIN_W-1:0] win_cnt;
    logic             sav_act;
    logic [SAV_W-1:0] sav_cnt;

    logic [2*CW-1:0]  dout_q;
    logic             dout_valid_q;
    logic             trs_q;
    logic [LN_W-1:0]  ln_q;
    logic             fmt_err_q;

    logic             eav_start_c;
    logic             vs_rise_c;
    logic             sav_fall_c;
    logic             win_busy_c;
    logic             sav_start_c;
    logic             conflict_c;
    logic [CW-1:0]    word_c;
    logic [2*CW-1:0]  out_c;
    logic             trs_c;
    logic [LN_W-1:0]  ln_next_c;
    logic             unused_vid_lsbs;

    assign din = {bus.vid_data[23:14], bus.vid_data[11:2], bus.vid_hsync, bus.vid_vsync, bus.vid_de};
    assign unused_vid_lsbs = ^{bus.vid_data[13:12], bus.vid_data[1:0]};

    // EAV keys off hsync rising at the oldest stage; SAV off hsync falling at the input,
    // which leaves exactly the last four blanking words in d3..d0.
    assign eav_start_c = d3.hs & ~hs_last;
    assign vs_rise_c   = d3.vs & ~vs_last;
    assign sav_fall_c  = ~din.hs & d0.hs;
    // EAV plus the LN/CRC slots form an 8-word window a SAV may not land in
    assign win_busy_c  = eav_start_c | win_act;
    assign sav_start_c = sav_fall_c & ~win_busy_c;
    assign conflict_c  = (sav_fall_c & win_busy_c) | (eav_start_c & sav_act);

    always_comb begin
        ln_next_c = ln_q;
        if (vs_rose || vs_rise_c) begin
            ln_next_c = LN_W'(VSYNC_LN);
        end else if (ln_q != '0) begin
            ln_next_c = (ln_q == LN_W'(LINES_PER_FRAME)) ? LN_W'(1) : ln_q + LN_W'(1);
        end
    end

    // Output word priority: EAV, SAV, blanking, active picture
    always_comb begin
        word_c = '0;
        out_c  = {BLANK_Y, BLANK_C};
        trs_c  = 1'b0;
        if (eav_start_c) begin
            out_c = {TRS_ONES, TRS_ONES};
            trs_c = 1'b1;
        end else if (win_act && !win_cnt[WIN_W-1]) begin
            word_c = trs_word(win_cnt[1:0], v_line, 1'b1);
            out_c  = {word_c, word_c};
        end else if (sav_start_c) begin
            out_c = {TRS_ONES, TRS_ONES};
            trs_c = 1'b1;
        end else if (sav_act) begin
            word_c = trs_word(sav_cnt, v_line, 1'b0);
            out_c  = {word_c, word_c};
        end else if (!d3.hs && !d3.vs && d3.de) begin
            out_c = {act_word(d3.y), act_word(d3.c)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d0           <= FILL;
            d1           <= FILL;
            d2           <= FILL;
            d3           <= FILL;
            hs_last      <= 1'b1;
            vs_last      <= 1'b1;
            vs_rose      <= 1'b0;
            v_line       <= 1'b0;
            win_act      <= 1'b0;
            win_cnt      <= '0;
            sav_act      <= 1'b0;
            sav_cnt      <= '0;
            dout_q       <= {BLANK_Y, BLANK_C};
            dout_valid_q <= 1'b0;
            trs_q        <= 1'b0;
            ln_q         <= '0;
            fmt_err_q    <= 1'b0;
        end else begin
            dout_valid_q <= bus.enable;
            if (bus.enable) begin
                d0      <= din;
                d1      <= d0;
                d2      <= d1;
                d3      <= d2;
                hs_last <= d3.hs;
                vs_last <= d3.vs;
                dout_q  <= out_c;
                trs_q   <= trs_c;

                if (eav_start_c) begin
                    v_line  <= d3.vs;
                    ln_q    <= ln_next_c;
                    vs_rose <= 1'b0;
                    win_act <= 1'b1;
                    win_cnt <= WIN_W'(1);
                end else begin
                    if (vs_rise_c) begin
                        vs_rose <= 1'b1;
                    end
                    if (win_act) begin
                        win_cnt <= win_cnt + WIN_W'(1);
                        if (&win_cnt) begin
                            win_act <= 1'b0;
                        end
                    end
                end

                // EAV always wins; a SAV overlapping it is dropped
                if (eav_start_c) begin
                    sav_act <= 1'b0;
                end else if (sav_start_c) begin
                    sav_act <= 1'b1;
                    sav_cnt <= SAV_W'(1);
                end else if (sav_act) begin
                    sav_cnt <= sav_cnt + SAV_W'(1);
                    if (&sav_cnt) begin
                        sav_act <= 1'b0;
                    end
                end

                if (conflict_c) begin
                    fmt_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.trs        = trs_q;
    assign bus.ln         = ln_q;
    assign bus.fmt_err    = fmt_err_q;
endmodule
